// File: rtl/freq_counter_pkg.sv
// -----------------------------------------------------------------------------
// freq_counter_pkg
// Shared types and constants for the gated frequency counter.
//   BCD_W      : width of one BCD digit
//   BCD_NINE   : largest decimal digit value
//   BCD_BLANK  : display code for a blanked (suppressed) digit
//   digit_t    : one packed BCD digit
//   state_t    : measurement control states (IDLE, PRIME, MEASURE)
// -----------------------------------------------------------------------------
package freq_counter_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] digit_t;

  localparam digit_t BCD_NINE  = 4'd9;
  localparam digit_t BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One decade (0..9) counter used as a link in a ripple-carry BCD chain.
// Ports:
//   clk_ref_in : reference clock
//   rstn_in    : asynchronous active-low reset
//   inc_in     : advance this digit by one
//   clr_in     : synchronous clear, wins over inc_in
//   digit_out  : current digit value
//   carry_out  : inc_in while the digit sits at 9 (feeds the next digit up)
// -----------------------------------------------------------------------------
module bcd_digit_counter
  import freq_counter_pkg::*;
(
  input  logic   clk_ref_in,
  input  logic   rstn_in,
  input  logic   inc_in,
  input  logic   clr_in,
  output digit_t digit_out,
  output logic   carry_out
);

  always_ff @(posedge clk_ref_in or negedge rstn_in) begin
    if (!rstn_in) begin
      digit_out <= '0;
    end else if (clr_in) begin
      digit_out <= '0;
    end else if (inc_in) begin
      digit_out <= (digit_out == BCD_NINE) ? digit_t'(0) : digit_out + 4'd1;
    end
  end

  // Carry is combinational so the whole chain resolves within one cycle.
  assign carry_out = inc_in & (digit_out == BCD_NINE);

endmodule

// File: rtl/freq_gate_counter.sv
// -----------------------------------------------------------------------------
// freq_gate_counter
// Counts rising edges of an asynchronous input over a fixed window of
// reference-clock cycles, in packed BCD, and publishes the result once per
// window with a one-cycle strobe. The first window after enable or reset is a
// priming window whose result is discarded.
//
// Parameters:
//   GATE_CYCLES : window length in clk_ref_in cycles (>= 4)
//   DIGITS      : number of BCD digits in the result
// Ports:
//   clk_ref_in       : reference clock (only clock)
//   rstn_in          : asynchronous active-low reset
//   clk_x_in         : unknown input, asynchronous to clk_ref_in
//   gate_en_in       : level-sensitive measurement enable
//   digits_out       : published packed BCD, digit 0 (units) in [3:0]
//   overflow_out     : published window exceeded 10^DIGITS-1 edges
//   result_valid_out : one-cycle strobe when digits_out/overflow_out update
//
// Build option:
//   FREQ_BLANK_LEADING_ZEROS_EN : when defined, leading zero digits above
//   digit 0 are published as 4'hF (blank). overflow_out is not affected.
// -----------------------------------------------------------------------------
module freq_gate_counter
  import freq_counter_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int DIGITS      = 8
) (
  input  logic                  clk_ref_in,
  input  logic                  rstn_in,
  input  logic                  clk_x_in,
  input  logic                  gate_en_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic                  overflow_out,
  output logic                  result_valid_out
);

  localparam int               CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(GATE_CYCLES - 1);

  function automatic logic all_nines(input digit_t [DIGITS-1:0] d);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[i] != BCD_NINE) r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] blank_leading(input digit_t [DIGITS-1:0] d);
    digit_t [DIGITS-1:0] r;
    logic                lead;
    r    = d;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (d[i] == digit_t'(0))) begin
        r[i] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  // Input synchronizer and edge detect
  logic s1, s2, prev;
  logic x_rise;

  always_ff @(posedge clk_ref_in or negedge rstn_in) begin
    if (!rstn_in) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= clk_x_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign x_rise = s2 & ~prev;

  // Control FSM and window counter
  state_t           state, state_nxt;
  logic [CNT_W-1:0] win_cnt;
  logic             active;
  logic             terminal;
  logic             publish;

  // A cleared enable takes effect in the same cycle so the aborted window
  // never reaches its terminal cycle.
  assign active   = (state != IDLE) && gate_en_in;
  assign terminal = active && (win_cnt == TERM);
  assign publish  = terminal && (state == MEASURE);

  always_ff @(posedge clk_ref_in or negedge rstn_in) begin
    if (!rstn_in) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gate_en_in)      state_nxt = PRIME;
      PRIME:   if (!gate_en_in)     state_nxt = IDLE;
               else if (terminal)   state_nxt = MEASURE;
      MEASURE: if (!gate_en_in)     state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_ref_in or negedge rstn_in) begin
    if (!rstn_in) begin
      win_cnt <= '0;
    end else if (!active || terminal) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  // BCD edge counter
  digit_t [DIGITS-1:0] bcd_cur;
  digit_t [DIGITS-1:0] bcd_pub;
  logic   [DIGITS-1:0] dig_inc;
  logic   [DIGITS-1:0] dig_carry;
  logic                bcd_sat;
  logic                bcd_clr;
  logic                ovf_evt;
  logic                ovf_sticky;

  assign bcd_sat = all_nines(bcd_cur);
  // Clearing on the terminal cycle hands the next window a zero count, so an
  // edge on that cycle lands only in the closing window's published value.
  assign bcd_clr = !active || terminal;
  assign ovf_evt = active && x_rise && bcd_sat;

  always_comb begin
    dig_inc    = '0;
    dig_inc[0] = active && x_rise && !bcd_sat;
    for (int i = 1; i < DIGITS; i++) begin
      dig_inc[i] = dig_carry[i-1];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk_ref_in (clk_ref_in),
      .rstn_in    (rstn_in),
      .inc_in     (dig_inc[g]),
      .clr_in     (bcd_clr),
      .digit_out  (bcd_cur[g]),
      .carry_out  (dig_carry[g])
    );
  end

  // Saturation keeps the chain from ripple-carrying out of the top digit.
  logic unused_top_carry;
  assign unused_top_carry = dig_carry[DIGITS-1];

  // Value including this cycle's edge, used when the window closes.
  always_comb begin
    bcd_pub = bcd_cur;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_inc[i]) begin
        bcd_pub[i] = (bcd_cur[i] == BCD_NINE) ? digit_t'(0) : bcd_cur[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_ref_in or negedge rstn_in) begin
    if (!rstn_in) begin
      ovf_sticky <= 1'b0;
    end else if (bcd_clr) begin
      ovf_sticky <= 1'b0;
    end else if (ovf_evt) begin
      ovf_sticky <= 1'b1;
    end
  end

  // Publication registers
  logic [4*DIGITS-1:0] pub_fmt;

`ifdef FREQ_BLANK_LEADING_ZEROS_EN
  assign pub_fmt = blank_leading(bcd_pub);
`else
  assign pub_fmt = bcd_pub;
  logic [4*DIGITS-1:0] unused_blank_fn;
  assign unused_blank_fn = blank_leading(bcd_pub);
`endif

  always_ff @(posedge clk_ref_in or negedge rstn_in) begin
    if (!rstn_in) begin
      digits_out       <= '0;
      overflow_out     <= 1'b0;
      result_valid_out <= 1'b0;
    end else begin
      result_valid_out <= publish;
      if (publish) begin
        digits_out   <= pub_fmt;
        overflow_out <= ovf_sticky | ovf_evt;
      end
    end
  end

endmodule

// File: doc/freq_gate_counter.md
# freq_gate_counter

Gated frequency-measurement stage of the OLED frequency counter. It samples the unknown input `clk_x_in` in the reference-clock domain and counts its rising edges over a fixed gate window of reference cycles. Counting is done directly in packed BCD. At each window end it publishes a stable result with a one-cycle strobe. It sits directly upstream of the OLED text/render stage, which consumes the digits and the overflow flag.

## Interface
- `GATE_CYCLES`, default 50_000_000: gate window length in `clk_ref_in` cycles; minimum 4.
- `DIGITS`, default 8: number of BCD digits in the result.
- `clk_ref_in`  input  1: reference clock; the only clock.
- `rstn_in`  input  1: reset, asynchronous and active-low.
- `clk_x_in`  input  1: unknown signal; asynchronous to `clk_ref_in`.
- `gate_en_in`  input  1: measurement enable; level-sensitive.
- `digits_out`  output  4*DIGITS: packed BCD result, digit 0 (units) in bits [3:0].
- `overflow_out`  output  1: published window exceeded 10^DIGITS−1 edges.
- `result_valid_out`  output  1: one-cycle strobe when `digits_out` and `overflow_out` update.

## Operation
- Input path:
  - 2-flop synchronizer `s1`→`s2`, then history flop `prev`.
  - Edge condition: `s2 & ~prev`.
- Window counter: runs 0..GATE_CYCLES−1. The terminal cycle is count == GATE_CYCLES−1; the counter wraps to 0 on the next cycle.
- BCD counter:
  - Increments by 1 on each edge cycle with ripple carry across digits.
  - Saturates at all-9s. An edge arriving while at all-9s sets the window's sticky overflow bit.
- States:
  - IDLE: window counter, BCD counter and overflow bit held at 0; no strobes.
    - IDLE→PRIME when `gate_en_in`=1.
  - PRIME: first window after enable or reset. It counts normally, but its result is discarded: nothing is published and no strobe is issued.
    - PRIME→MEASURE at the terminal cycle.
  - MEASURE: on each terminal cycle:
    - publish BCD value plus that cycle's edge, and the overflow bit (including any overflow caused by that edge);
    - clear BCD counter and overflow bit;
    - the next window starts on the following cycle.
  - Any state → IDLE when `gate_en_in`=0. A partially counted window is aborted. Published outputs keep their last value.
- Edge on the terminal cycle:
  - counted in the closing window;
  - never also counted in the next window.

## Timing
- Reset values:
  - `digits_out`=0, `overflow_out`=0, `result_valid_out`=0;
  - `s1`/`s2`/`prev`=0; state=IDLE.
- Reset mid-window: aborts immediately. After release, measurement restarts in PRIME if enabled.
- Edge latency: a rising edge on `clk_x_in` reaches the counter 2–3 cycles later.
- Maximum countable rate: one edge per 2 `clk_ref_in` cycles. Inputs toggling faster alias.
- Publication: `digits_out`, `overflow_out` and `result_valid_out` are registered and all change on the cycle after the terminal cycle. They are stable for at least GATE_CYCLES−1 cycles between strobes.
- Strobe period in steady MEASURE: exactly GATE_CYCLES cycles.
- First strobe after enable: 2·GATE_CYCLES+1 cycles after the first cycle with `gate_en_in`=1 seen in IDLE.

## Configuration
- `FREQ_BLANK_LEADING_ZEROS_EN`:
  - Defined: at publication, leading zero digits above digit 0 are replaced by the blank code 4'hF. Digit 0 is never blanked, so the value 0 shows as F…F0.
  - Undefined: plain zero-padded BCD.
- `overflow_out` is unaffected by the macro.

## Structure
- Package `freq_counter_pkg`:
  - `BCD_W`=4, `BCD_BLANK`=4'hF;
  - state enum (IDLE, PRIME, MEASURE);
  - digit typedef.
- Sub-module `bcd_digit_counter`: one decade counter.
  - Inputs: `inc_in`, `clr_in`.
  - Outputs: `digit_out`, `carry_out` (=`inc_in` & digit==9).
  - Instantiated DIGITS times via generate; the all-9s saturation check sits in the parent.

## Test plan
Bench uses GATE_CYCLES=100, DIGITS=3, macro undefined unless stated.
- `clk_x_in` toggles every 2 cycles, enable high → first strobe at cycle 201 after enable, then every 100 cycles; `digits_out`=0x025, `overflow_out`=0.
- DIGITS=1, `clk_x_in` toggles every cycle (50 edges/window) → `digits_out`=0x9, `overflow_out`=1 on every strobe.
- `clk_x_in` held high through reset and after → every published result 0x000; one single rising edge placed on a terminal cycle → counted exactly once, result 0x001.
- `gate_en_in` dropped 50 cycles into a MEASURE window → no strobe, outputs hold the prior 0x025; re-enable → next strobe exactly 201 cycles later.
- `rstn_in` pulsed low mid-window → all outputs 0 asynchronously; measurement restarts with PRIME.
- Macro defined, 25 edges/window → `digits_out`=0xF25; zero edges → 0xFF0.
